// File: rtl/sntc_ldpc_enc_sched.sv
// ---------------------------------------------------------------------------
// sntc_ldpc_enc_sched
//
// Lets two independent message sources share one LDPC encoder. Each job runs
// through these steps:
//   1. Pick a requester by round-robin and latch its message.
//   2. Pulse enc_clr to the encoder for one cycle.
//   3. Wait a bounded number of cycles for enc_valid.
//   4. Hand the captured codeword back, tagged with the requester id, over a
//      valid/ready handshake.
//
// Optional feature (compile-time macro):
//   SNTC_ENC_SCHED_ERRCNT_EN - adds output err_cnt[15:0]. It is a saturating
//   count of results delivered with out_err=1. Only rstn clears it.
//
// Ports:
//   clk        single clock, rising edge
//   rstn       asynchronous reset, active HIGH (1 = reset)
//   flush      synchronous abort of the current job
//   req_valid  [1:0] per-requester message valid
//   req_ready  [1:0] per-requester accept (one-hot or zero, IDLE only)
//   req_msg0   [NN-MM-1:0] requester 0 message
//   req_msg1   [NN-MM-1:0] requester 1 message
//   enc_msg    [NN-MM-1:0] latched message driven to the encoder
//   enc_clr    one-cycle encoder clear
//   enc_cword  [NN-1:0] encoder codeword
//   enc_valid  encoder codeword-check valid
//   out_valid  result valid
//   out_ready  result accept
//   out_cword  [NN-1:0] captured codeword
//   out_id     requester owning the result
//   out_err    1 = job timed out without enc_valid
//   busy       scheduler not idle
//   err_cnt    [15:0] timed-out result count (macro builds only)
// ---------------------------------------------------------------------------
module sntc_ldpc_enc_sched #(
    parameter int unsigned NN      = 'h000d0,
    parameter int unsigned MM      = 'h000a8,
    parameter int unsigned ENC_LAT = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [NN-MM-1:0] req_msg0,
    input  logic [NN-MM-1:0] req_msg1,
    output logic [NN-MM-1:0] enc_msg,
    output logic             enc_clr,
    input  logic [NN-1:0]    enc_cword,
    input  logic             enc_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NN-1:0]    out_cword,
    output logic             out_id,
    output logic             out_err,
    output logic             busy
`ifdef SNTC_ENC_SCHED_ERRCNT_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    // The WAIT counter is 8 bits wide, so both bounds are compared at 8 bits.
    localparam logic [7:0] ENC_LAT_C = ENC_LAT[7:0];
    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        WAIT,
        OUT
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [NN-MM-1:0]   msg_q;
    logic               id_q;
    logic               rr_q;     // requester that wins a tie
    logic [7:0]         cnt_q;
    logic [NN-1:0]      cw_q;
    logic               err_q;

    logic               grant;
    logic               grant_id;
    logic               capture;
    logic               capture_err;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        req_ready   = '0;
        enc_clr     = 1'b0;
        grant       = 1'b0;
        grant_id    = 1'b0;
        capture     = 1'b0;
        capture_err = 1'b0;

        // The clear pulse belongs to the CLR cycle even when that cycle is
        // also being flushed. The encoder gets cleared either way.
        if (state_q == CLR) begin
            enc_clr = 1'b1;
        end

        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant = 1'b1;
                        // Both requesting: the round-robin pointer decides.
                        // Only one requesting: that one wins.
                        grant_id  = (req_valid == 2'b11) ? rr_q : req_valid[1];
                        req_ready = grant_id ? 2'b10 : 2'b01;
                        state_d   = CLR;
                    end
                end
                CLR: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    // enc_valid is ignored until the encoder's minimum
                    // latency has elapsed.
                    if ((cnt_q >= ENC_LAT_C) && enc_valid) begin
                        capture = 1'b1;
                        state_d = OUT;
                    end else if (cnt_q == TIMEOUT_C) begin
                        capture     = 1'b1;
                        capture_err = 1'b1;
                        state_d     = OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Job data: message/id latch, round-robin pointer, wait counter, result
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            msg_q <= '0;
            id_q  <= 1'b0;
            rr_q  <= 1'b0;
            cnt_q <= '0;
            cw_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (grant) begin
                msg_q <= grant_id ? req_msg1 : req_msg0;
                id_q  <= grant_id;
                rr_q  <= ~grant_id;
            end

            if (flush || (state_q == CLR)) begin
                cnt_q <= '0;
            end else if ((state_q == WAIT) && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (capture) begin
                cw_q  <= enc_cword;
                err_q <= capture_err;
            end
        end
    end

`ifdef SNTC_ENC_SCHED_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            err_cnt_q <= '0;
        end else if ((state_q == OUT) && out_ready && err_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign enc_msg   = msg_q;
    assign out_valid = (state_q == OUT);
    assign out_cword = cw_q;
    assign out_id    = id_q;
    assign out_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/sntc_ldpc_enc_sched.md
Name: sntc_ldpc_enc_sched

Overview:
Two-requester scheduler that shares one LDPC encoder instance (message in, NN-bit codeword plus codeword-valid out) between independent message sources. Per job it does four things: round-robin arbitration, message latching, an encoder clear pulse, and a bounded wait for a valid codeword. It returns the codeword with a requester tag over a valid/ready handshake. It sits between the message producers and the encoder wrapper.

Parameters:
NN, 'h000d0, codeword length in bits.
MM, 'h000a8, parity/check count; message width is NN-MM.
ENC_LAT, 2, minimum WAIT cycles before enc_valid is sampled (1..TIMEOUT).
TIMEOUT, 15, maximum WAIT cycles before the job is forced out with error (<=255).

Ports:
clk  in  1  single clock; all logic on rising edge.
rstn  in  1  asynchronous, active-high reset (1 = reset), per team port naming.
flush  in  1  synchronous abort; drops the current job.
req_valid  in  2  per-requester message valid.
req_ready  out  2  per-requester accept; one-hot or zero.
req_msg0  in  NN-MM  requester 0 message.
req_msg1  in  NN-MM  requester 1 message.
enc_msg  out  NN-MM  message to the encoder, held from msg_q.
enc_clr  out  1  one-cycle clear to the encoder.
enc_cword  in  NN  encoder codeword.
enc_valid  in  1  encoder codeword-check valid.
out_valid  out  1  result valid.
out_ready  in  1  result accept.
out_cword  out  NN  captured codeword.
out_id  out  1  requester that owns the result.
out_err  out  1  1 = timed out without enc_valid.
busy  out  1  state != IDLE.

Behaviour:
- Reset values: state=IDLE; req_ready=0; enc_clr=0; enc_msg=0; out_valid=0; out_cword=0; out_id=0; out_err=0; busy=0; rr pointer=0 (requester 0 has priority first); counter=0.
- States: IDLE, CLR, WAIT, OUT.
- IDLE transition:
  - If any req_valid and not flush, grant the requester selected by round-robin.
  - Round-robin: the requester not granted last time wins a tie; a single requester always wins.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch msg_q=req_msg[g] and id_q=g; toggle the rr pointer away from g; go to CLR.
  - req_ready is 0 in every other state.
- CLR: enc_clr=1 for exactly this cycle; counter cleared to 0; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If counter>=ENC_LAT and enc_valid=1: capture cw_q=enc_cword, err_q=0, go to OUT.
  - Otherwise, if counter==TIMEOUT: capture cw_q=enc_cword, err_q=1, go to OUT.
  - enc_valid before ENC_LAT is ignored.
- OUT:
  - out_valid=1; out_cword, out_id and out_err are held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE. No new grant is issued in the same cycle; earliest next grant is the following cycle.
- enc_msg=msg_q in all states, so it is stable through CLR/WAIT.
- Latency with ENC_LAT=2 and enc_valid already high: grant at cycle 0, CLR at 1, WAIT at 2..4 (counter 0,1,2), capture at 4, out_valid at cycle 5.
- flush:
  - From any state, return to IDLE next cycle with out_valid=0 and counter=0.
  - The rr pointer is kept; the dropped job is not reported.
  - flush and req_valid in IDLE in the same cycle: flush wins, req_ready=0.
- Reset mid-job: all state clears immediately (async); the job is lost.
- Counter is 8 bits and saturates; it never wraps.

Optional Feature:
Macro SNTC_ENC_SCHED_ERRCNT_EN.
- Defined: adds output port err_cnt [15:0].
  - Increments on every OUT handshake with out_err=1 and saturates at 'hFFFF.
  - Cleared by rstn only; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Only req_valid=2'b01, msg0='h12_3456_789A, enc_valid tied 1, ENC_LAT=2 -> req_ready=2'b01 at cycle 0; enc_clr at cycle 1; out_valid at cycle 5 with out_id=0, out_err=0, out_cword=enc_cword.
- req_valid=2'b11 held for 4 jobs, out_ready=1 -> grant order 0,1,0,1; out_id follows the same order.
- enc_valid=0 throughout, TIMEOUT=15 -> out_valid at cycle 18 with out_err=1 (err_cnt=1 when macro defined).
- out_ready=0 for 10 cycles in OUT while enc_cword changes -> out_cword, out_id and out_err unchanged; no req_ready; one handshake on release.
- flush asserted in WAIT -> out_valid never rises for that job; busy=0 next cycle; next grant goes to the other requester.
- rstn pulsed during WAIT -> all outputs return to reset values asynchronously; the next job runs normally from requester 0.
